// File: rtl/operand_sequencer.sv
// Operand entry sequencer: three load strobes capture A, B and F in turn from the
// switches, then valid holds while the complete set drives downstream logic.
//
// state | meaning
// S_A   | waiting for the first operand
// S_B   | waiting for the second operand
// S_F   | waiting for the operation select
// S_RUN | A, B, F complete and valid
module operand_sequencer #(
  parameter int NBITS_OPERATORS   = 3,
  parameter int NBITS_OPER_SELECT = 2,
  parameter int NBITS_COUNT       = 4
) (
  input  logic                                clk_2,
  input  logic                                reset,
  input  logic        [NBITS_OPERATORS-1:0]   data_in,
  input  logic                                load,
  input  logic                                clear,
  output logic signed [NBITS_OPERATORS-1:0]   A,
  output logic signed [NBITS_OPERATORS-1:0]   B,
  output logic        [NBITS_OPER_SELECT-1:0] F,
  output logic                                valid,
  output logic        [1:0]                   stage,
  output logic        [NBITS_COUNT-1:0]       count
);

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_F   = 2'b10,
    S_RUN = 2'b11
  } state_t;

  localparam logic [NBITS_COUNT-1:0] CNT_ONE = {{(NBITS_COUNT-1){1'b0}}, 1'b1};

  state_t                              state_q, state_d;
  logic signed [NBITS_OPERATORS-1:0]   a_q, a_d;
  logic signed [NBITS_OPERATORS-1:0]   b_q, b_d;
  logic        [NBITS_OPER_SELECT-1:0] f_q, f_d;
  logic                                valid_q, valid_d;
  logic        [NBITS_COUNT-1:0]       count_q, count_d;
  logic                                load_q;
  logic                                strobe;

  assign strobe = load & ~load_q;

  // load_q resets high so a load held through reset release is not taken as an edge.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      load_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      valid_q <= valid_d;
      count_q <= count_d;
      load_q  <= load;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    valid_d = valid_q;
    count_d = count_q;
    if (clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      f_d     = '0;
      valid_d = 1'b0;
    end else if (strobe) begin
      unique case (state_q)
        S_A: begin
          a_d     = data_in;
          state_d = S_B;
        end
        S_B: begin
          b_d     = data_in;
          state_d = S_F;
        end
        S_F: begin
          f_d     = data_in[NBITS_OPER_SELECT-1:0];
          valid_d = 1'b1;
          count_d = count_q + CNT_ONE;
          state_d = S_RUN;
        end
        S_RUN: begin
          a_d     = data_in;
          valid_d = 1'b0;
          state_d = S_B;
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign F     = f_q;
  assign valid = valid_q;
  assign stage = state_q;
  assign count = count_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: an entry-level model checked every cycle,
// plus literal expectations at the notable points of each scenario.
module tb_operand_sequencer;

  logic              clk_2;
  logic              reset;
  logic        [2:0] data_in;
  logic              load;
  logic              clear;
  logic signed [2:0] A;
  logic signed [2:0] B;
  logic        [1:0] F;
  logic              valid;
  logic        [1:0] stage;
  logic        [3:0] count;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  operand_sequencer #(
    .NBITS_OPERATORS(3),
    .NBITS_OPER_SELECT(2),
    .NBITS_COUNT(4)
  ) dut (
    .clk_2(clk_2),
    .reset(reset),
    .data_in(data_in),
    .load(load),
    .clear(clear),
    .A(A),
    .B(B),
    .F(F),
    .valid(valid),
    .stage(stage),
    .count(count)
  );

  initial begin
    clk_2 = 0;
    forever #5 clk_2 = ~clk_2;
  end

  // Model: fields entered so far in the current entry (3 = complete), the values,
  // and the number of completed entries.
  int m_fields = 0;
  int m_a = 0;
  int m_b = 0;
  int m_f = 0;
  int m_count = 0;
  bit m_load_prev = 1;
  bit m_edge;
  int slot;

  always @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      m_fields = 0; m_a = 0; m_b = 0; m_f = 0; m_count = 0; m_load_prev = 1;
    end else begin
      m_edge = load && !m_load_prev;
      m_load_prev = load;
      if (clear) begin
        m_fields = 0; m_a = 0; m_b = 0; m_f = 0;
      end else if (m_edge) begin
        slot = (m_fields == 3) ? 0 : m_fields;
        if (slot == 0) m_a = $signed(data_in);
        else if (slot == 1) m_b = $signed(data_in);
        else m_f = int'(data_in) % 4;
        m_fields = slot + 1;
        if (m_fields == 3) m_count = (m_count + 1) % 16;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_2) begin
    if (cmp_en) begin
      chk("model_A", int'(A), m_a);
      chk("model_B", int'(B), m_b);
      chk("model_F", int'(F), m_f);
      chk("model_valid", int'(valid), (m_fields == 3) ? 1 : 0);
      chk("model_stage", int'(stage), m_fields);
      chk("model_count", int'(count), m_count);
    end
  end

  task automatic pulse(input int val);
    @(negedge clk_2);
    data_in = 3'(val);
    load = 1;
    @(negedge clk_2);
    load = 0;
  endtask

  initial begin
    reset = 0; data_in = 0; load = 0; clear = 0;
    #1 reset = 1;
    @(negedge clk_2);
    @(negedge clk_2);
    cmp_en = 1;
    chk("rst_A", int'(A), 0);
    chk("rst_stage", int'(stage), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_count", int'(count), 0);
    reset = 0;

    // first entry: 3, -2, sub
    pulse(3);
    pulse(6);
    chk("pre_valid", int'(valid), 0);
    chk("pre_stage", int'(stage), 2);
    pulse(1);
    chk("e1_A", int'(A), 3);
    chk("e1_B", int'(B), -2);
    chk("e1_F", int'(F), 1);
    chk("e1_stage", int'(stage), 3);
    chk("e1_valid", int'(valid), 1);
    chk("e1_count", int'(count), 1);
    repeat (3) @(negedge clk_2);
    chk("hold_valid", int'(valid), 1);
    chk("hold_A", int'(A), 3);

    // new entry from S_RUN
    pulse(7);
    chk("run_A", int'(A), -1);
    chk("run_valid", int'(valid), 0);
    chk("run_stage", int'(stage), 1);
    chk("run_B", int'(B), -2);
    chk("run_F", int'(F), 1);

    // clear beats a simultaneous strobe in S_F
    pulse(2);
    chk("sf_stage", int'(stage), 2);
    @(negedge clk_2);
    clear = 1; load = 1; data_in = 3;
    @(negedge clk_2);
    clear = 0; load = 0;
    chk("clr_stage", int'(stage), 0);
    chk("clr_A", int'(A), 0);
    chk("clr_B", int'(B), 0);
    chk("clr_F", int'(F), 0);
    chk("clr_valid", int'(valid), 0);
    chk("clr_count", int'(count), 1);

    // held load captures once
    @(negedge clk_2);
    data_in = 5; load = 1;
    repeat (10) @(negedge clk_2);
    chk("held_A", int'(A), -3);
    chk("held_stage", int'(stage), 1);
    load = 0;

    // asynchronous reset mid-entry, with load held high across release
    #2 reset = 1; load = 1; data_in = 4;
    #1;
    chk("async_stage", int'(stage), 0);
    chk("async_A", int'(A), 0);
    chk("async_count", int'(count), 0);
    @(negedge clk_2);
    reset = 0;
    repeat (3) @(negedge clk_2);
    chk("nocap_stage", int'(stage), 0);
    chk("nocap_A", int'(A), 0);
    load = 0;
    pulse(2);
    chk("recap_A", int'(A), 2);
    chk("recap_stage", int'(stage), 1);

    // 16 complete entries wrap the counter
    @(negedge clk_2);
    clear = 1;
    @(negedge clk_2);
    clear = 0;
    for (int i = 0; i < 16; i++) begin
      pulse(i % 8);
      pulse((i + 3) % 8);
      pulse(i % 4);
      chk("wrap_valid", int'(valid), 1);
      chk("wrap_count", int'(count), (i + 1) % 16);
    end
    chk("wrap_final", int'(count), 0);

    @(negedge clk_2);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
